// File: rtl/seg7_scan_ctrl_if.sv
// Value handshake into the two-digit 7-segment scan controller.
// The producer drives valid/data; the controller answers with ready.
interface seg7_scan_ctrl_if #(
    parameter int W = 7
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment controller: sequential binary-to-BCD conversion of an
// accepted value plus a free-running one-hot digit scan on a shared segment bus.
module seg7_scan_ctrl #(
    parameter int W       = 7,
    parameter int REFRESH = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_ctrl_if.slave     bus,
    output logic [6:0]          seg,
    output logic [1:0]          dig_en,
    output logic                ovf
);
    localparam int CW = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DISP = 2'd2
    } state_t;

    state_t         state_r;
    logic           s_ready_r;
    logic [W-1:0]   shift_r;
    logic [19:0]    bcd_r;
    logic [4:0]     step_r;
    logic [3:0]     ones_r;
    logic [3:0]     tens_r;
    logic           ovf_r;
    logic           shown_r;
    logic [CW-1:0]  scan_cnt_r;
    logic           idx_r;
    logic [6:0]     seg_r;
    logic [1:0]     dig_en_r;

    logic           accept_s;
    logic           last_s;
    logic [19:0]    bcd_step_s;
    logic [3:0]     ones_v_s;
    logic [3:0]     tens_v_s;
    logic           ovf_v_s;
    logic           shown_v_s;
    logic           wrap_s;
    logic           idx_nxt_s;
    logic [6:0]     seg_nxt_s;

    // One shift-and-add-3 step over five BCD digits (enough for W up to 16).
    function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic bit_in);
        logic [19:0] adj;
        adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
            end else begin
                adj[d*4 +: 4] = adj[d*4 +: 4];
            end
        end
        return {adj[18:0], bit_in};
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0:    digit_seg = 7'h3F;
            4'd1:    digit_seg = 7'h06;
            4'd2:    digit_seg = 7'h5B;
            4'd3:    digit_seg = 7'h4F;
            4'd4:    digit_seg = 7'h66;
            4'd5:    digit_seg = 7'h6D;
            4'd6:    digit_seg = 7'h7D;
            4'd7:    digit_seg = 7'h07;
            4'd8:    digit_seg = 7'h7F;
            4'd9:    digit_seg = 7'h6F;
            default: digit_seg = 7'h00;
        endcase
    endfunction

    // Conversion step, load lookahead and next segment pattern.
    always_comb begin
        accept_s   = bus.s_valid && s_ready_r;
        last_s     = (state_r == CONV) && (step_r == 5'(W - 1));
        bcd_step_s = dabble_step(bcd_r, shift_r[W-1]);
        wrap_s     = (scan_cnt_r == CW'(REFRESH - 1));
        idx_nxt_s  = wrap_s ? ~idx_r : idx_r;
        // seg is registered, so it is built from the values the display
        // registers and digit index take at this same edge.
        if (last_s) begin
            ones_v_s  = bcd_step_s[3:0];
            tens_v_s  = bcd_step_s[7:4];
            ovf_v_s   = |bcd_step_s[19:8];
            shown_v_s = 1'b1;
        end else begin
            ones_v_s  = ones_r;
            tens_v_s  = tens_r;
            ovf_v_s   = ovf_r;
            shown_v_s = shown_r;
        end
        if (!shown_v_s) begin
            seg_nxt_s = 7'h00;
        end else if (ovf_v_s) begin
            seg_nxt_s = 7'h40;
        end else if (!idx_nxt_s) begin
            seg_nxt_s = digit_seg(ones_v_s);
        end else if (tens_v_s == 4'd0) begin
            seg_nxt_s = 7'h00;
        end else begin
            seg_nxt_s = digit_seg(tens_v_s);
        end
    end

    // Handshake / conversion FSM and display registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            s_ready_r <= 1'b1;
            shift_r   <= '0;
            bcd_r     <= 20'd0;
            step_r    <= 5'd0;
            ones_r    <= 4'd0;
            tens_r    <= 4'd0;
            ovf_r     <= 1'b0;
            shown_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DISP: begin
                    if (accept_s) begin
                        shift_r   <= bus.s_data;
                        bcd_r     <= 20'd0;
                        step_r    <= 5'd0;
                        s_ready_r <= 1'b0;
                        state_r   <= CONV;
                    end
                end
                CONV: begin
                    bcd_r   <= bcd_step_s;
                    shift_r <= shift_r << 1;
                    step_r  <= step_r + 5'd1;
                    if (last_s) begin
                        ones_r    <= ones_v_s;
                        tens_r    <= tens_v_s;
                        ovf_r     <= ovf_v_s;
                        shown_r   <= 1'b1;
                        s_ready_r <= 1'b1;
                        state_r   <= DISP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    s_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Free-running digit scan and registered segment / enable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            idx_r      <= 1'b0;
            seg_r      <= 7'h00;
            dig_en_r   <= 2'b01;
        end else begin
            scan_cnt_r <= wrap_s ? '0 : scan_cnt_r + CW'(1);
            idx_r      <= idx_nxt_s;
            seg_r      <= seg_nxt_s;
            dig_en_r   <= idx_nxt_s ? 2'b10 : 2'b01;
        end
    end

    assign bus.s_ready = s_ready_r;
    assign seg         = seg_r;
    assign dig_en      = dig_en_r;
    assign ovf         = ovf_r;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a value-level model.
module tb_seg7_scan_ctrl;
    localparam int W       = 7;
    localparam int REFRESH = 4;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    seg7_scan_ctrl_if #(.W(W)) bus ();

    seg7_scan_ctrl #(.W(W), .REFRESH(REFRESH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .seg    (seg),
        .dig_en (dig_en),
        .ovf    (ovf)
    );

    logic [6:0] dec_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected segment pattern for a displayed value (-1 = nothing shown).
    function automatic int exp_seg(input int val, input int idx);
        if (val < 0)   return 0;
        if (val > 99)  return 'h40;
        if (idx == 0)  return int'(dec_tab[val % 10]);
        if (val / 10 == 0) return 0;
        return int'(dec_tab[val / 10]);
    endfunction

    // Reference model: displayed value, pending conversion countdown, scan phase.
    int m_val   = -1;
    int m_pend  = 0;
    int m_left  = 0;
    bit m_busy  = 1'b0;
    int m_phase = 0;
    bit m_on    = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_on    = 1'b1;
                m_val   = -1;
                m_busy  = 1'b0;
                m_left  = 0;
                m_phase = 0;
            end else if (m_on) begin
                m_phase = (m_phase + 1) % (2 * REFRESH);
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_val  = m_pend;
                    end
                end else if (bus.s_valid) begin
                    m_busy = 1'b1;
                    m_pend = int'(bus.s_data);
                    m_left = W;
                end
            end
            #1;
            if (m_on) begin
                check("model_seg",    int'(seg),         exp_seg(m_val, m_phase / REFRESH));
                check("model_dig_en", int'(dig_en),      (m_phase / REFRESH) == 1 ? 2 : 1);
                check("model_ready",  int'(bus.s_ready), m_busy ? 0 : 1);
                check("model_ovf",    int'(ovf),         (m_val > 99) ? 1 : 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Present v until accepted; returns the number of cycles s_ready stayed low.
    task automatic send(input int v, output int lowcnt);
        int guard;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 7'(v);
        guard = 0;
        while (!bus.s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", guard < 50 ? 1 : 0, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 7'($urandom_range(0, 127));
        lowcnt = 0;
        while (!bus.s_ready && lowcnt < 50) begin
            lowcnt++;
            @(negedge clk);
            bus.s_data = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic check_digits(input string name, input int ones, input int tens, input int o);
        int g;
        g = 0;
        while (dig_en != 2'b01 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({name, "_ones"}, int'(seg), ones);
        g = 0;
        while (dig_en != 2'b10 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({name, "_tens"}, int'(seg), tens);
        check({name, "_ovf"}, int'(ovf), o);
    endtask

    initial begin
        int lc;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 7'd0;

        // Reset and idle scan pattern.
        do_reset();
        check("rst_seg",   int'(seg),         0);
        check("rst_ready", int'(bus.s_ready), 1);
        check("rst_ovf",   int'(ovf),         0);
        for (int i = 0; i < 8; i++) begin
            check("rst_scan", int'(dig_en), (i < 4) ? 1 : 2);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        send(42, lc);
        check("lat_42", lc, W);
        check_digits("v42", 'h5B, 'h66, 0);

        send(7, lc);
        check_digits("v7", 'h07, 'h00, 0);
        send(0, lc);
        check_digits("v0", 'h3F, 'h00, 0);

        send(100, lc);
        check_digits("v100", 'h40, 'h40, 1);
        send(127, lc);
        check_digits("v127", 'h40, 'h40, 1);
        send(99, lc);
        check_digits("v99", 'h6F, 'h6F, 0);

        // Back-to-back with s_valid held: 13 at edge k, 58 at edge k+8.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 7'd13;
        check("b2b_ready0", int'(bus.s_ready), 1);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("b2b_busy", int'(bus.s_ready), 0);
            bus.s_data = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        check("b2b_ready7", int'(bus.s_ready), 1);
        check("b2b_ones13", int'(seg), dig_en == 2'b01 ? 'h4F : 'h06);
        bus.s_data = 7'd58;
        @(negedge clk);
        check("b2b_accept58", int'(bus.s_ready), 0);
        bus.s_valid = 1'b0;
        repeat (W) @(negedge clk);
        check_digits("v58", 'h7F, 'h6D, 0);

        // Reset three cycles into a conversion of 55.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 7'd55;
        @(negedge clk);
        bus.s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_seg",   int'(seg),         0);
        check("mid_dig",   int'(dig_en),      1);
        check("mid_ready", int'(bus.s_ready), 1);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_never55", int'(seg), 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus.s_valid = ($urandom_range(0, 3) == 0);
            bus.s_data  = 7'($urandom_range(0, 127));
            rst         = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Sequencing controller for the two-digit 7-segment display path: accepts a binary value over a valid/ready handshake, converts it to two BCD digits with a sequential shift-and-add-3 engine, and time-multiplexes the digits onto one shared segment bus with a one-hot digit enable. It sits between the value-producing logic and the display pins, and it owns both the converter and the scan schedule.

## Interface

- W, default 7: input value width; legal range 4..16.
- REFRESH, default 4: clock cycles each digit is driven before the scan advances; must be ≥1.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  s_data holds a value to display.
- s_ready  out  1  controller can accept a value.
- s_data  in  W  unsigned binary value.
- seg  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- dig_en  out  2  one-hot digit select: 2'b01 selects ones, 2'b10 selects tens.
- ovf  out  1  the displayed value exceeded 99.

## Operation

- **FSM states:** IDLE (nothing shown yet), CONV (conversion running), DISP (value held).
- **IDLE:**
  - s_ready = 1.
  - The accept condition s_valid && s_ready latches s_data and moves the FSM to CONV.
- **CONV:**
  - s_ready = 0.
  - Runs exactly W shift-and-add-3 steps, one per cycle, on an internal BCD register that is at least 12 bits wide.
  - During the last CONV cycle, the display registers (ones, tens, ovf, shown flag) load atomically and the FSM moves to DISP.
  - s_data changes during CONV are ignored.
- **DISP:**
  - s_ready = 1.
  - An accept restarts CONV. The old value stays displayed until the new load.
- **Overflow:** if the latched value is >99, ovf = 1 and both digits show a dash (7'h40). Otherwise ovf = 0.
- **Leading-zero blanking:** when the tens digit is 0 and ovf = 0, the tens position shows blank (7'h00). A value of 0 shows 3F on ones.
- **Digit decode:** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- **Shown flag:** while the flag is clear (IDLE after reset), seg = 7'h00 for both digits.
- **Scan:**
  - A free-running counter runs from 0 to REFRESH-1. On wrap, the digit index toggles.
  - The scan is independent of the FSM and never stalls during CONV.
  - dig_en is derived from the registered digit index.
  - seg is decoded from the registered display registers and the registered index, so there is no combinational path from s_valid or s_data to any output.

## Timing

- **Reset values:** seg = 7'h00, dig_en = 2'b01, s_ready = 1, ovf = 0, FSM in IDLE, scan counter = 0, display registers = 0, shown flag clear.
- **Reset mid-CONV:** aborts the conversion. Next cycle shows the reset values above; the previously displayed value is discarded.
- **Accept-to-display latency:** for an accept at edge k, the display registers load at edge k+W. seg reflects the new value from edge k+W onward, on whichever digit is selected.
- **s_ready:**
  - Falls after edge k.
  - Rises again after edge k+W.
  - The earliest next accept is at edge k+W+1.
  - Throughput is one value per W+1 cycles.
- **Held s_valid:** s_valid held high through CONV is not an accept; it is accepted at the first edge where s_ready = 1.
- **Simultaneous events:** an accept coinciding with a scan wrap executes both; neither delays the other.
- **Scan period:**
  - dig_en toggles every REFRESH cycles, so the full scan period is 2·REFRESH.
  - With REFRESH = 1, dig_en toggles every cycle.

## Test plan

- **Reset:** hold rst for 2 cycles, release, and idle for 10 cycles. Required: seg = 00, s_ready = 1, ovf = 0; dig_en shows 01 for 4 cycles, then 10 for 4 cycles (W=7, REFRESH=4).
- **Normal value:** accept 42. Required: s_ready low for exactly 7 cycles. From edge k+7: dig_en = 01 gives seg = 5B, dig_en = 10 gives seg = 66, ovf = 0.
- **Blanking:** accept 7, then accept 0. Required: first value gives ones = 07 and tens = 00; second value gives ones = 3F and tens = 00.
- **Overflow:** accept 100, then accept 127. Required: ovf = 1 and both digits = 40 for each value. A following accept of 99 gives ovf = 0 and both digits = 6F.
- **Handshake and throughput:**
  - Hold s_valid high with 13 and then 58 presented back-to-back.
  - Required: 58 is accepted exactly at edge k+8; 13 is visible from k+7 until 58 loads at k+15; s_data changes during CONV have no effect.
- **Reset mid-CONV:** accept 55 and assert rst 3 cycles later. Required: next cycle shows seg = 00, dig_en = 01, s_ready = 1; 55 is never displayed.
